// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared mode/state encodings and width helper for prio_enc_arb
package prio_enc_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic int clog2(input int v);
    clog2 = 0;
    while ((1 << clog2) < v) clog2++;
  endfunction
endpackage

// File: rtl/prio_enc_arb_if.sv
// prio_enc_arb_if: req/mode/out_ready from sources+consumer, out_valid/out_idx/out_onehot/none_o from arbiter
interface prio_enc_arb_if import prio_enc_pkg::*; #(parameter int N = 4) ();
  localparam int W = clog2(N);
  logic [N-1:0] req;
  logic mode;
  logic out_ready;
  logic out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic none_o;
  modport master (output req, mode, out_ready, input out_valid, out_idx, out_onehot, none_o);
  modport slave (input req, mode, out_ready, output out_valid, out_idx, out_onehot, none_o);
endinterface

// File: rtl/prio_pick.sv
// prio_pick: combinational winner search (req, start ptr, mode -> idx, found), highest rotated index wins
module prio_pick import prio_enc_pkg::*; #(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         found
);
  int st;
  always_comb begin
    st = (mode == MODE_RR) ? int'(ptr) : N - 1;
    found = 1'b0;
    idx = '0;
    for (int j = 0; j < N; j++) begin
      if (req[(j + st + 1) % N]) begin
        found = 1'b1;
        idx = W'((j + st + 1) % N);
      end
    end
  end
endmodule

// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered fixed/round-robin arbiter; clk, rst_n (async low), bus (slave: req/mode/out_ready in, out_valid/out_idx/out_onehot/none_o out)
module prio_enc_arb import prio_enc_pkg::*; #(
  parameter int N = 4
) (
  input logic clk,
  input logic rst_n,
  prio_enc_arb_if.slave bus
);
  localparam int W = clog2(N);
  state_t state, state_n;
  logic [W-1:0] ptr, ptr_n, idx, pick_idx;
  logic rr, none, found, acc, cap;
  always_comb begin
    acc = (state == HOLD) & bus.out_ready;
    cap = (state == IDLE) | bus.out_ready;
    ptr_n = (acc & rr) ? ((idx == '0) ? W'(N - 1) : idx - W'(1)) : ptr;
    state_n = cap ? (found ? HOLD : IDLE) : state;
  end
  prio_pick #(.N(N)) u_pick (
    .req(bus.req),
    .ptr(ptr_n),
    .mode(bus.mode),
    .idx(pick_idx),
    .found(found)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= W'(N - 1);
      idx <= '0;
      rr <= 1'b0;
      none <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      none <= cap & ~found;
      if (cap) begin
        idx <= pick_idx;
        rr <= bus.mode;
      end
    end
  end
  assign bus.out_valid = (state == HOLD);
  assign bus.out_idx = idx;
  assign bus.out_onehot = (state == HOLD) ? N'(1) << idx : '0;
  assign bus.none_o = none;
endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: directed and randomized checks of prio_enc_arb against a behavioural model
module tb_prio_enc_arb;
  logic clk, rst_n;
  int errors = 0, checks = 0;
  int m_valid, m_idx, m_ptr, m_rr, m_none;
  prio_enc_arb_if #(.N(4)) bus ();
  prio_enc_arb #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int win(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) if (r[(start - k + 4) % 4]) return (start - k + 4) % 4;
    return -1;
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask
  task automatic step(input logic [3:0] r, input logic m, input logic rd);
    bus.req = r;
    bus.mode = m;
    bus.out_ready = rd;
    @(negedge clk);
  endtask
  always @(posedge clk or negedge rst_n) begin : model
    int p;
    if (!rst_n) begin
      m_valid <= 0;
      m_idx <= 0;
      m_ptr <= 3;
      m_rr <= 0;
      m_none <= 0;
    end else begin
      p = m_ptr;
      if (m_valid != 0 && bus.out_ready && m_rr != 0) p = (m_idx == 0) ? 3 : m_idx - 1;
      m_ptr <= p;
      if (m_valid == 0 || bus.out_ready) begin
        if (bus.req != 4'b0) begin
          m_valid <= 1;
          m_idx <= win(bus.req, bus.mode ? p : 3);
          m_rr <= int'(bus.mode);
          m_none <= 0;
        end else begin
          m_valid <= 0;
          m_none <= 1;
        end
      end else m_none <= 0;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", int'(bus.out_valid), m_valid);
      chk("model_none", int'(bus.none_o), m_none);
      chk("model_onehot", int'(bus.out_onehot), (m_valid != 0) ? (1 << m_idx) : 0);
      if (m_valid != 0) chk("model_idx", int'(bus.out_idx), m_idx);
    end
  end
  initial begin
    rst_n = 1'b0;
    bus.req = 4'b0;
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_idx", int'(bus.out_idx), 0);
    chk("rst_onehot", int'(bus.out_onehot), 0);
    chk("rst_none", int'(bus.none_o), 0);
    #1 rst_n = 1'b1;
    step(4'b0000, 0, 1);
    chk("t1_none", int'(bus.none_o), 1);
    chk("t1_none_valid", int'(bus.out_valid), 0);
    step(4'b0001, 0, 1); chk("t1_idx0", int'(bus.out_idx), 0); chk("t1_oh0", int'(bus.out_onehot), 1);
    chk("t1_none_drop", int'(bus.none_o), 0);
    step(4'b0010, 0, 1); chk("t1_idx1", int'(bus.out_idx), 1); chk("t1_oh1", int'(bus.out_onehot), 2);
    step(4'b0100, 0, 1); chk("t1_idx2", int'(bus.out_idx), 2); chk("t1_oh2", int'(bus.out_onehot), 4);
    step(4'b1000, 0, 1); chk("t1_idx3", int'(bus.out_idx), 3); chk("t1_oh3", int'(bus.out_onehot), 8);
    step(4'b1011, 0, 1); chk("t1_idx1011", int'(bus.out_idx), 3); chk("t1_oh1011", int'(bus.out_onehot), 8);
    step(4'b0110, 0, 1); chk("t2_cap", int'(bus.out_idx), 2);
    for (int i = 0; i < 5; i++) begin
      step(4'b1000, 0, 0);
      chk("t2_hold_idx", int'(bus.out_idx), 2);
      chk("t2_hold_oh", int'(bus.out_onehot), 4);
      chk("t2_hold_valid", int'(bus.out_valid), 1);
    end
    step(4'b1000, 0, 1); chk("t2_release", int'(bus.out_idx), 3);
    begin
      int exp_rr[6] = '{3, 2, 1, 0, 3, 2};
      for (int i = 0; i < 6; i++) begin
        step(4'b1111, 1, 1);
        chk("t3_rr", int'(bus.out_idx), exp_rr[i]);
      end
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    begin
      int exp_sp[4] = '{3, 0, 3, 0};
      for (int i = 0; i < 4; i++) begin
        step(4'b1001, 1, 1);
        chk("t4_sparse", int'(bus.out_idx), exp_sp[i]);
      end
    end
    step(4'b0101, 1, 1); chk("t4_after0", int'(bus.out_idx), 2);
    step(4'b1111, 1, 1); chk("t5_pre1", int'(bus.out_idx), 1);
    step(4'b0100, 1, 1); chk("t5_pre2", int'(bus.out_idx), 2);
    step(4'b0100, 1, 0); chk("t5_hold", int'(bus.out_idx), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(bus.out_valid), 0);
    chk("t5_async_idx", int'(bus.out_idx), 0);
    chk("t5_async_oh", int'(bus.out_onehot), 0);
    #1 rst_n = 1'b1;
    step(4'b1001, 1, 1); chk("t5_ptr_reset", int'(bus.out_idx), 3);
    step(4'b1100, 0, 1); chk("t6_fixed_a", int'(bus.out_idx), 3);
    step(4'b1100, 0, 1); chk("t6_fixed_b", int'(bus.out_idx), 3);
    step(4'b1100, 1, 1); chk("t6_rr", int'(bus.out_idx), 2);
    for (int i = 0; i < 500; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
